// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO between instruction fetch and decode.
// Each entry carries {pc, inst, imm_sel}. imm_sel is predecoded from the
// opcode at push time, so decode never decodes the opcode on the
// format-select path. Every output comes from a register or from a
// register mux selected by the registered read pointer.
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [2:0]                 out_imm_sel,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Immediate format codes driven to the immediate generator
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic [2:0]  sel_q  [DEPTH];

    logic [2:0] imm_sel_d;
    logic       push;
    logic       pop;

    // Ready depends only on occupancy, never on the consumer side
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_pc      = pc_q[rd_q];
    assign out_inst    = inst_q[rd_q];
    assign out_imm_sel = sel_q[rd_q];
    assign count       = count_q;

    // Opcode predecode of the incoming word into an immediate format
    always_comb begin
        imm_sel_d = IMM_NONE;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: imm_sel_d = IMM_I;
            7'b0100011:             imm_sel_d = IMM_S;
            7'b1100011:             imm_sel_d = IMM_B;
            7'b0110111, 7'b0010111: imm_sel_d = IMM_U;
            7'b1101111:             imm_sel_d = IMM_J;
            default:                imm_sel_d = IMM_NONE;
        endcase
    end

    // Pointer and occupancy next state; flush wins over push/pop
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Slot storage: reset fills every slot with a NOP so the idle head is benign
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'h0000_0000;
                inst_q[i] <= 32'h0000_0013;
                sel_q[i]  <= IMM_I;
            end
        end else if (push && !flush) begin
            pc_q[wr_q]   <= in_pc;
            inst_q[wr_q] <= in_inst;
            sel_q[wr_q]  <= imm_sel_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2): a vector table for single-cycle
// behaviour plus hand-written streaming and wrap-around sequences.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_sel;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_imm_sel(out_imm_sel),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_cnt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_sel;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] inst, input logic ordy,
                       input logic ov, input logic ir, input logic [1:0] cnt,
                       input logic [31:0] epc, input logic [31:0] einst, input logic [2:0] esel);
        vec_t v;
        v.rstn = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
        v.e_ov = ov; v.e_ir = ir; v.e_cnt = cnt; v.e_pc = epc; v.e_inst = einst; v.e_sel = esel;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int cyc;
        logic [31:0] exp_inst;

        // reset held two cycles with an offer present
        add(1'b0,1'b0,1'b1,32'h100,32'h00500093,1'b0, 1'b0,1'b1,2'd0,32'h0,32'h13,3'd0);
        add(1'b0,1'b0,1'b1,32'h100,32'h00500093,1'b0, 1'b0,1'b1,2'd0,32'h0,32'h13,3'd0);
        // fill to full, third offer stalls, then drain in order
        add(1'b1,1'b0,1'b1,32'h100,32'h00500093,1'b0, 1'b1,1'b1,2'd1,32'h100,32'h00500093,3'd0);
        add(1'b1,1'b0,1'b1,32'h104,32'hFE000EE3,1'b0, 1'b1,1'b0,2'd2,32'h100,32'h00500093,3'd0);
        add(1'b1,1'b0,1'b1,32'h108,32'h00000013,1'b0, 1'b1,1'b0,2'd2,32'h100,32'h00500093,3'd0);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,           1'b1,1'b1,2'd1,32'h104,32'hFE000EE3,3'd2);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,           1'b0,1'b1,2'd0,32'h100,32'h00500093,3'd0);
        // predecode sweep: sw, lui, jal, add, jalr, auipc, ecall
        add(1'b1,1'b0,1'b1,32'h10,32'h00A12223,1'b1, 1'b1,1'b1,2'd1,32'h10,32'h00A12223,3'd1);
        add(1'b1,1'b0,1'b1,32'h14,32'h123450B7,1'b1, 1'b1,1'b1,2'd1,32'h14,32'h123450B7,3'd3);
        add(1'b1,1'b0,1'b1,32'h18,32'h008000EF,1'b1, 1'b1,1'b1,2'd1,32'h18,32'h008000EF,3'd4);
        add(1'b1,1'b0,1'b1,32'h1C,32'h002081B3,1'b1, 1'b1,1'b1,2'd1,32'h1C,32'h002081B3,3'd7);
        add(1'b1,1'b0,1'b1,32'h20,32'h00008067,1'b1, 1'b1,1'b1,2'd1,32'h20,32'h00008067,3'd0);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,          1'b0,1'b1,2'd0,32'h1C,32'h002081B3,3'd7);
        add(1'b1,1'b0,1'b1,32'h24,32'h00000017,1'b1, 1'b1,1'b1,2'd1,32'h24,32'h00000017,3'd3);
        add(1'b1,1'b0,1'b1,32'h28,32'h00000073,1'b1, 1'b1,1'b1,2'd1,32'h28,32'h00000073,3'd0);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,          1'b0,1'b1,2'd0,32'h24,32'h00000017,3'd3);
        // flush from full with offer and pop present; slots untouched
        add(1'b1,1'b0,1'b1,32'h30,32'h00000013,1'b0, 1'b1,1'b1,2'd1,32'h30,32'h00000013,3'd0);
        add(1'b1,1'b0,1'b1,32'h34,32'h00C000EF,1'b0, 1'b1,1'b0,2'd2,32'h30,32'h00000013,3'd0);
        add(1'b1,1'b1,1'b1,32'h38,32'h00000023,1'b1, 1'b0,1'b1,2'd0,32'h34,32'h00C000EF,3'd4);
        add(1'b1,1'b0,1'b1,32'h200,32'h00000013,1'b0,1'b1,1'b1,2'd1,32'h200,32'h00000013,3'd0);
        // flush with an acceptable push: the push must not land in slot 1
        add(1'b1,1'b1,1'b1,32'h204,32'h0000006F,1'b1,1'b0,1'b1,2'd0,32'h200,32'h00000013,3'd0);
        add(1'b1,1'b0,1'b1,32'h300,32'h00000003,1'b0,1'b1,1'b1,2'd1,32'h300,32'h00000003,3'd0);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,          1'b0,1'b1,2'd0,32'h30,32'h00000013,3'd0);
        // mid-operation reset (also beats a concurrent flush)
        add(1'b1,1'b0,1'b1,32'h400,32'h00000037,1'b0,1'b1,1'b1,2'd1,32'h400,32'h00000037,3'd3);
        add(1'b0,1'b1,1'b1,32'h404,32'h00000013,1'b1,1'b0,1'b1,2'd0,32'h0,32'h13,3'd0);
        add(1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b1,2'd0,32'h0,32'h13,3'd0);

        foreach (vq[i]) begin
            rstn      = vq[i].rstn;
            flush     = vq[i].flush;
            in_valid  = vq[i].iv;
            in_pc     = vq[i].pc;
            in_inst   = vq[i].inst;
            out_ready = vq[i].ordy;
            @(posedge clk);
            #1;
            $display("vec %0d: ov=%0d ir=%0d cnt=%0d pc=%h inst=%h sel=%0d",
                     i, out_valid, in_ready, count, out_pc, out_inst, out_imm_sel);
            check($sformatf("v%0d_out_valid", i), 32'(out_valid),   32'(vq[i].e_ov));
            check($sformatf("v%0d_in_ready", i),  32'(in_ready),    32'(vq[i].e_ir));
            check($sformatf("v%0d_count", i),     32'(count),       32'(vq[i].e_cnt));
            check($sformatf("v%0d_out_pc", i),    out_pc,           vq[i].e_pc);
            check($sformatf("v%0d_out_inst", i),  out_inst,         vq[i].e_inst);
            check($sformatf("v%0d_imm_sel", i),   32'(out_imm_sel), 32'(vq[i].e_sel));
        end

        // streaming: queue empty here; head always shows the previous push
        rstn = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pc   = 32'(4 * i);
            in_inst = 32'h13 | (32'(i) << 20);
            @(posedge clk);
            #1;
            $display("stream %0d: cnt=%0d pc=%h inst=%h", i, count, out_pc, out_inst);
            check($sformatf("stream%0d_count", i), 32'(count), 32'd1);
            check($sformatf("stream%0d_pc", i),    out_pc,     32'(4 * i));
            check($sformatf("stream%0d_inst", i),  out_inst,   32'h13 | (32'(i) << 20));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("stream end: cnt=%0d ov=%0d", count, out_valid);
        check("stream_drain_count", 32'(count), 32'd0);

        // wrap-around: 5 entries, consumer ready every other cycle
        sent = 0; recv = 0; cyc = 0;
        while (recv < 5 && cyc < 40) begin
            in_valid  = (sent < 5);
            in_pc     = 32'h500 + 32'(4 * sent);
            in_inst   = 32'h13 | (32'(sent) << 7);
            out_ready = (cyc % 2 == 0);
            if (out_valid && out_ready) begin
                exp_inst = 32'h13 | (32'(recv) << 7);
                $display("wrap pop %0d: pc=%h inst=%h", recv, out_pc, out_inst);
                check($sformatf("wrap%0d_pc", recv),   out_pc,   32'h500 + 32'(4 * recv));
                check($sformatf("wrap%0d_inst", recv), out_inst, exp_inst);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
            check($sformatf("wrap_c%0d_count", cyc), 32'(count), 32'(sent - recv));
            check($sformatf("wrap_c%0d_occupancy_le_depth", cyc), 32'((sent - recv) <= 2), 32'd1);
        end
        check("wrap_all_received", 32'(recv), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between instruction fetch and decode in the RV32I core. It buffers fetched {pc, instruction} pairs in a small FIFO with valid/ready handshakes on both sides and a synchronous flush for redirects. At push time it predecodes each instruction's immediate format, so decode drives the immediate generator's format select directly from the queue head with no opcode decoding on that path.

## Interface
- DEPTH, 2, number of entries; power of two, ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  reset; synchronous, active-low
- flush  input  1  discard all entries (branch/jump redirect, trap)
- in_valid  input  1  fetch offers an entry
- in_ready  output  1  queue can accept an entry this cycle
- in_pc  input  32  address of offered instruction
- in_inst  input  32  offered instruction word
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  32  head pc
- out_inst  output  32  head instruction word
- out_imm_sel  output  3  predecoded immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 7 none
- count  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0], imm_sel[2:0]}; read pointer, write pointer and count registers; pointers wrap modulo DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. out_valid = (count != 0).
- Outputs show the entry at the read pointer. When out_valid=0, outputs hold whatever that slot last contained.
- Predecode on in_inst[6:0]:
  - 0000011, 0010011, 1100111, 1110011 → 0
  - 0100011 → 1
  - 1100011 → 2
  - 0110111, 0010111 → 3
  - 1101111 → 4
  - all others, including 0110011 R-type → 7
  - Computed combinationally from in_inst and written with the entry. Never recomputed at the head.
- Push only: write slot[wr], wr+1, count+1.
- Pop only: rd+1, count−1.
- Push and pop in the same cycle (0 < count < DEPTH): both pointers advance, count unchanged. Because in_ready=0 when full, this cannot occur when full. When empty, out_valid=0, so there is no pop.
- flush=1: next cycle rd=wr=0 and count=0. A push or pop in the flush cycle is discarded and has no effect. Slot contents are left unchanged.
- Flush takes priority over push and pop. Reset takes priority over flush.
- Reset (rstn=0 at an edge):
  - rd=0, wr=0, count=0.
  - Every slot is loaded with pc=0x00000000, inst=0x00000013 (NOP), imm_sel=0.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0x00000013, out_imm_sel=0.
- No bypass: an entry pushed while the queue is empty is not visible in the same cycle.

## Timing
- Push-to-head latency is 1 cycle: an entry pushed at edge N into an empty queue gives out_valid=1 after edge N.
- Sustained throughput is 1 entry/cycle when out_ready is held at 1 and count ≥ 1.
- in_ready deasserts the cycle after the push that fills the queue. It reasserts the cycle after the first pop from full.
- flush asserted at edge N: after edge N, out_valid=0 and in_ready=1. A push at edge N+1 is accepted normally.
- rstn mid-operation behaves identically to reset from idle. Partially filled contents are lost.
- All outputs are registered or driven by a mux of registers selected by a registered pointer. There is no combinational in→out path.

## Test plan
- Reset: hold rstn=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, count=0, out_inst=0x00000013, out_imm_sel=0. No entry is accepted.
- Fill and drain, DEPTH=2, out_ready=0:
  - Push (0x100, 0x00500093 addi) and (0x104, 0xFE000EE3 beq) → count=2, in_ready=0, head out_pc=0x100, out_imm_sel=0.
  - Third offer is stalled.
  - Raise out_ready → heads appear in order, second has out_imm_sel=2. count returns to 0.
- Streaming: in_valid=out_ready=1 for 8 cycles with pcs 0x0..0x1C → count stays 1 after the first edge. Outputs follow inputs by 1 cycle with no loss or duplication.
- Predecode sweep: one push each of 0x00A12223 (sw), 0x123450B7 (lui), 0x008000EF (jal), 0x002081B3 (add), 0x00008067 (jalr) → out_imm_sel = 1, 3, 4, 7, 0.
- Flush: with count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, and the offered entry is absent. A following push (0x200, 0x00000013) appears at the head one cycle later.
- Wrap-around: push and pop 5 entries with alternating out_ready → FIFO order is preserved across pointer wrap, and count never exceeds DEPTH.
